// File: rtl/serial_pkg.sv
// Shared definitions for the lab 4 character loop receiver and transmitter.
package serial_pkg;

  localparam int unsigned DEFAULT_OVERSAMPLE = 16;
  localparam int unsigned DEFAULT_DATA_BITS  = 8;
  localparam int unsigned BIC_W              = 4;
  localparam logic        LINE_IDLE          = 1'b1;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_t;

endpackage

// File: rtl/serial_char_rx_sync2.sv
// Two-flop synchronizer for the asynchronous loop line; both stages reset to the idle level.
module sync2
  import serial_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= LINE_IDLE;
      sync_q <= LINE_IDLE;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/serial_char_rx.sv
// Oversampling serial character receiver feeding the Nios II PIO inputs.
// Define SERIAL_RX_PARITY_EN to expect an even-parity bit after the data bits.
module serial_char_rx
  import serial_pkg::*;
#(
  parameter int unsigned OVERSAMPLE = DEFAULT_OVERSAMPLE,
  parameter int unsigned SAMPLE_DIV = 1,
  parameter int unsigned DATA_BITS  = DEFAULT_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 rx,
  input  logic                 rx_ack,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 rx_valid,
  output logic [BIC_W-1:0]     bic,
  output logic                 framing_err,
  output logic                 overrun
);

  localparam int unsigned SCNT_W = $clog2(OVERSAMPLE);
  localparam int unsigned DIV_W  = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

  localparam logic [SCNT_W-1:0] SCNT_MID_PRE  = SCNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [SCNT_W-1:0] SCNT_MAX      = SCNT_W'(OVERSAMPLE - 1);
  localparam logic [DIV_W-1:0]  DIV_MAX       = DIV_W'(SAMPLE_DIV - 1);
  localparam logic [BIC_W-1:0]  BIC_LAST_DATA = BIC_W'(DATA_BITS + 1);

  logic                 rx_s;
  logic                 prev_q;
  logic                 fall_c;
  logic                 tick_c;
  logic                 mid_c;

  logic [DIV_W-1:0]     div_q,    div_d;
  logic [SCNT_W-1:0]    scnt_q,   scnt_d;
  rx_state_t            state_q,  state_d;
  logic [BIC_W-1:0]     bic_q,    bic_d;
  logic [DATA_BITS-1:0] shreg_q,  shreg_d;
  logic                 fin_q,    fin_d;
  logic                 stop_q,   stop_d;
  logic [DATA_BITS-1:0] data_q,   data_d;
  logic                 valid_q,  valid_d;
  logic                 ovr_q,    ovr_d;
  logic                 fe_q,     fe_d;

  sync2 u_sync2 (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (rx),
    .q       (rx_s)
  );

  assign fall_c = prev_q & ~rx_s;
  assign tick_c = (div_q == DIV_MAX);
  assign mid_c  = tick_c && (scnt_q == SCNT_MID_PRE);

  // Tick divider and in-bit sample counter, both realigned to the start edge.
  always_comb begin
    div_d  = div_q;
    scnt_d = scnt_q;
    if ((state_q == RX_IDLE) && fall_c) begin
      div_d  = '0;
      scnt_d = '0;
    end else begin
      div_d = tick_c ? '0 : div_q + 1'b1;
      if (tick_c) begin
        scnt_d = (scnt_q == SCNT_MAX) ? '0 : scnt_q + 1'b1;
      end
    end
  end

  // Character FSM; fin_q marks the cycle after the final mid-bit sample where the result is applied.
  always_comb begin
    state_d = state_q;
    bic_d   = bic_q;
    shreg_d = shreg_q;
    fin_d   = 1'b0;
    stop_d  = stop_q;
    data_d  = data_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    fe_d    = 1'b0;

    if (rx_ack && valid_q) begin
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end

    case (state_q)
      RX_IDLE: begin
        if (fall_c) begin
          state_d = RX_START;
          bic_d   = BIC_W'(1);
        end
      end

      RX_START: begin
        if (mid_c) begin
          if (!rx_s) begin
            state_d = RX_DATA;
            bic_d   = BIC_W'(2);
          end else begin
            state_d = RX_IDLE;
            bic_d   = '0;
          end
        end
      end

      RX_DATA: begin
        if (mid_c) begin
          shreg_d = {rx_s, shreg_q[DATA_BITS-1:1]};
          bic_d   = bic_q + 1'b1;
          if (bic_q == BIC_LAST_DATA) begin
`ifdef SERIAL_RX_PARITY_EN
            state_d = RX_PARITY;
`else
            state_d = RX_STOP;
`endif
          end
        end
      end

`ifdef SERIAL_RX_PARITY_EN
      RX_PARITY: begin
        if (fin_q) begin
          state_d = RX_IDLE;
          bic_d   = '0;
        end else if (mid_c) begin
          if ((^shreg_q) == rx_s) begin
            state_d = RX_STOP;
            bic_d   = bic_q + 1'b1;
          end else begin
            // Flag while bic still points at the parity bit.
            fe_d  = 1'b1;
            fin_d = 1'b1;
          end
        end
      end
`endif

      RX_STOP: begin
        if (fin_q) begin
          state_d = RX_IDLE;
          bic_d   = '0;
          if (!stop_q) begin
            fe_d = 1'b1;
          end else if (!valid_q || rx_ack) begin
            data_d  = shreg_q;
            valid_d = 1'b1;
          end else begin
            ovr_d = 1'b1;
          end
        end else if (mid_c) begin
          stop_d = rx_s;
          fin_d  = 1'b1;
        end
      end

      default: begin
        state_d = RX_IDLE;
        bic_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_q  <= LINE_IDLE;
      div_q   <= '0;
      scnt_q  <= '0;
      state_q <= RX_IDLE;
      bic_q   <= '0;
      shreg_q <= '0;
      fin_q   <= 1'b0;
      stop_q  <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
      fe_q    <= 1'b0;
    end else begin
      prev_q  <= rx_s;
      div_q   <= div_d;
      scnt_q  <= scnt_d;
      state_q <= state_d;
      bic_q   <= bic_d;
      shreg_q <= shreg_d;
      fin_q   <= fin_d;
      stop_q  <= stop_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
      fe_q    <= fe_d;
    end
  end

  assign data_out    = data_q;
  assign rx_valid    = valid_q;
  assign bic         = bic_q;
  assign framing_err = fe_q;
  assign overrun     = ovr_q;

endmodule

// File: tb/tb_serial_char_rx.sv
// Randomized bench for serial_char_rx against a frame-level receive model.
`timescale 1ns/1ps
module tb_serial_char_rx;
  import serial_pkg::*;

  localparam int unsigned OS = DEFAULT_OVERSAMPLE;
  localparam int unsigned DB = DEFAULT_DATA_BITS;
`ifdef SERIAL_RX_PARITY_EN
  localparam int unsigned NPAR = 1;
  localparam int unsigned LAT  = 171;
`else
  localparam int unsigned NPAR = 0;
  localparam int unsigned LAT  = 155;
`endif

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          rx = 1'b1;
  logic          rx_ack = 1'b0;
  logic [DB-1:0] data_out;
  logic          rx_valid;
  logic [3:0]    bic;
  logic          framing_err;
  logic          overrun;

  serial_char_rx dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .rx          (rx),
    .rx_ack      (rx_ack),
    .data_out    (data_out),
    .rx_valid    (rx_valid),
    .bic         (bic),
    .framing_err (framing_err),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Observation of bic trajectory, framing pulses and rx_valid rise time.
  logic [3:0]  last_bic = 4'd0;
  logic        last_valid = 1'b0;
  int          fe_cnt = 0;
  int          fe_bic = 0;
  int unsigned rise_cyc = 0;
  logic [3:0]  bic_log[$];

  always @(negedge clk) begin
    if (bic != last_bic) bic_log.push_back(bic);
    last_bic = bic;
    if (framing_err) begin
      fe_cnt++;
      fe_bic = int'(bic);
    end
    if (rx_valid && !last_valid) rise_cyc = cyc;
    last_valid = rx_valid;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference model of the consumer-visible state.
  logic [DB-1:0] m_data = '0;
  logic          m_valid = 1'b0;
  logic          m_ovr = 1'b0;

  task automatic check_outputs(input string tag);
    check_eq({tag, ".data"},  32'(data_out), 32'(m_data));
    check_eq({tag, ".valid"}, 32'(rx_valid), 32'(m_valid));
    check_eq({tag, ".ovr"},   32'(overrun),  32'(m_ovr));
  endtask

  task automatic ack_pulse();
    rx_ack = 1'b1;
    @(negedge clk);
    rx_ack = 1'b0;
    if (m_valid) begin
      m_valid = 1'b0;
      m_ovr   = 1'b0;
    end
    check_eq("ack.valid", 32'(rx_valid), 32'(m_valid));
    check_eq("ack.ovr",   32'(overrun),  32'(m_ovr));
  endtask

  // Drives one character bit-aligned to negedges; optionally acks on the load edge or aborts via reset.
  task automatic send_frame(input logic [DB-1:0] d, input bit stop_lvl, input bit par_flip,
                            input bit ack_at_load, input int abort_bic,
                            output int unsigned e0, output bit aborted);
    logic bits[$];
    bits.delete();
    bits.push_back(1'b0);
    for (int i = 0; i < int'(DB); i++) bits.push_back(d[i]);
`ifdef SERIAL_RX_PARITY_EN
    bits.push_back((^d) ^ par_flip);
`endif
    bits.push_back(stop_lvl);
    aborted = 1'b0;
    bic_log.delete();
    e0 = cyc + 1;
    foreach (bits[j]) begin
      for (int k = 0; k < int'(OS); k++) begin
        if (abort_bic > 0 && int'(bic) == abort_bic) begin
          reset_n = 1'b0;
          rx      = 1'b1;
          rx_ack  = 1'b0;
          aborted = 1'b1;
          return;
        end
        rx     = bits[j];
        rx_ack = ack_at_load && (cyc == e0 + LAT - 1);
        @(negedge clk);
      end
    end
    rx     = 1'b1;
    rx_ack = 1'b0;
  endtask

  task automatic run_frame(input logic [DB-1:0] d, input bit stop_lvl, input bit par_flip,
                           input bit ack_at_load, input int gap);
    int unsigned e0;
    bit          ab;
    bit          par_fail;
    bit          ok;
    bit          prev_valid;
    int          fe0;
    int          top;
    par_fail   = (NPAR != 0) && par_flip;
    ok         = stop_lvl && !par_fail;
    prev_valid = m_valid;
    fe0        = fe_cnt;
    send_frame(d, stop_lvl, par_flip, ack_at_load, 0, e0, ab);
    repeat (gap) @(negedge clk);

    if (ack_at_load && m_valid) begin
      m_valid = 1'b0;
      m_ovr   = 1'b0;
    end
    if (ok) begin
      if (!m_valid) begin
        m_data  = d;
        m_valid = 1'b1;
      end else begin
        m_ovr = 1'b1;
      end
    end

    check_outputs("frame");
    check_eq("fe_pulses", 32'(fe_cnt - fe0), ok ? 32'd0 : 32'd1);
    if (ok && !prev_valid) check_eq("latency", rise_cyc - e0, 32'(LAT));
`ifdef SERIAL_RX_PARITY_EN
    if (par_fail) check_eq("fe_bic", 32'(fe_bic), 32'(DB + 2));
`endif
    top = int'(DB) + 2 + int'(NPAR) - (par_fail ? 1 : 0);
    check_eq("bic_len", 32'(bic_log.size()), 32'(top + 1));
    if (bic_log.size() == top + 1) begin
      for (int i = 0; i <= top; i++)
        check_eq("bic_seq", 32'(bic_log[i]), (i == top) ? 32'd0 : 32'(i + 1));
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned e0;
    bit          ab;
    int          fe0;

    repeat (3) @(negedge clk);
    check_outputs("reset");
    check_eq("reset.bic", 32'(bic), 32'd0);
    check_eq("reset.fe",  32'(framing_err), 32'd0);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);

    run_frame(8'h41, 1'b1, 1'b0, 1'b0, 6);
    ack_pulse();
    run_frame(8'h5A, 1'b1, 1'b0, 1'b0, 4);

    ack_pulse();
    run_frame(8'h33, 1'b1, 1'b0, 1'b0, 3);
    run_frame(8'hCC, 1'b1, 1'b0, 1'b0, 3);

    ack_pulse();
    run_frame(8'h7E, 1'b0, 1'b0, 1'b0, 5);

    run_frame(8'h11, 1'b1, 1'b0, 1'b0, 3);
    run_frame(8'h22, 1'b1, 1'b0, 1'b0, 3);
    run_frame(8'h44, 1'b1, 1'b0, 1'b1, 3);

    // Short low glitch must be rejected as a false start.
    fe0 = fe_cnt;
    bic_log.delete();
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (30) @(negedge clk);
    check_eq("glitch.len", 32'(bic_log.size()), 32'd2);
    if (bic_log.size() == 2) begin
      check_eq("glitch.b0", 32'(bic_log[0]), 32'd1);
      check_eq("glitch.b1", 32'(bic_log[1]), 32'd0);
    end
    check_eq("glitch.fe", 32'(fe_cnt - fe0), 32'd0);
    check_outputs("glitch");

`ifdef SERIAL_RX_PARITY_EN
    ack_pulse();
    run_frame(8'h41, 1'b1, 1'b0, 1'b0, 4);
    ack_pulse();
    run_frame(8'h41, 1'b1, 1'b1, 1'b0, 4);
`endif

    // Reset in the middle of a character.
    send_frame(8'h96, 1'b1, 1'b0, 1'b0, 5, e0, ab);
    check_eq("abort_hit", 32'(ab), 32'd1);
    #1;
    m_data  = '0;
    m_valid = 1'b0;
    m_ovr   = 1'b0;
    check_outputs("midreset");
    check_eq("midreset.bic", 32'(bic), 32'd0);
    check_eq("midreset.fe",  32'(framing_err), 32'd0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (20) @(negedge clk);
    run_frame(8'h41, 1'b1, 1'b0, 1'b0, 4);

    for (int n = 0; n < 16; n++) begin
      logic [DB-1:0] d;
      bit            st;
      bit            pf;
      bit            al;
      d  = DB'($urandom);
      st = ($urandom_range(0, 5) != 0);
      pf = (NPAR != 0) && ($urandom_range(0, 5) == 0);
      al = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 1) == 1) ack_pulse();
      run_frame(d, st, pf, al, int'($urandom_range(2, 20)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
